// File: rtl/down_timer_pkg.sv
// down_timer_pkg: shared types and defaults for the dual-channel down timer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package down_timer_pkg;

    // Per-channel FSM: IDLE holds, COUNT decrements on each tick
    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH    = 64;
    localparam int DEFAULT_PRESCALE = 4;

    // Channel indices into the 2-bit Expire/Busy/Sticky vectors
    localparam int CH_FAST = 0;
    localparam int CH_SLOW = 1;

endpackage

// File: rtl/down_timer_if.sv
// down_timer_if: control and status bundle between software-side driver and the down timer.
// Latency: n/a (wires only).
// Backpressure: none; every command is accepted in the cycle it is presented.
// Optional Sticky vector present when DOWN_TIMER_STICKY_EN is defined.
interface down_timer_if #(
    parameter int WIDTH = down_timer_pkg::DEFAULT_WIDTH
);
    logic             En;
    logic             Slt;
    logic             Load;
    logic [WIDTH-1:0] LoadData;
    logic             AutoReload;
    logic [WIDTH-1:0] Output0;
    logic [WIDTH-1:0] Output1;
    logic [1:0]       Expire;
    logic [1:0]       Busy;
`ifdef DOWN_TIMER_STICKY_EN
    logic [1:0]       Sticky;
`endif

    // Driver side: issues commands, observes counts and flags
    modport master (
        output En, Slt, Load, LoadData, AutoReload,
        input  Output0, Output1, Expire, Busy
`ifdef DOWN_TIMER_STICKY_EN
        , input Sticky
`endif
    );

    // Timer side: consumes commands, produces counts and flags
    modport slave (
        input  En, Slt, Load, LoadData, AutoReload,
        output Output0, Output1, Expire, Busy
`ifdef DOWN_TIMER_STICKY_EN
        , output Sticky
`endif
    );

endinterface

// File: rtl/down_timer_channel.sv
// down_timer_channel: one down-counting channel with reload value, one-shot/periodic mode and expiry pulse.
// Latency: load visible after the loading edge; terminal tick updates count and Expire on the same edge.
// Backpressure: none; the parent gates tick/load and the channel never stalls.
module down_timer_channel
    import down_timer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             tick,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             expire,
    output logic             busy
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] reload_val;
    logic [WIDTH-1:0] count_nxt;
    logic             mode;
    logic             expire_nxt;
    logic             terminal;

    // Terminal step is taken at 1 so the count never underflows past 0
    assign terminal = !load && tick && (state == COUNT) && (count == WIDTH'(1));

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state: load wins, a nonzero load arms the channel, one-shot expiry disarms it
    always_comb begin
        state_nxt = state;
        if (load)                  state_nxt = (load_data != '0) ? COUNT : IDLE;
        else if (terminal && !mode) state_nxt = IDLE;
    end

    // Outputs and datapath next values: load, terminal reload/clear, or plain decrement
    always_comb begin
        busy       = (state == COUNT);
        count_nxt  = count;
        expire_nxt = 1'b0;
        if (load) begin
            count_nxt = load_data;
        end else if (terminal) begin
            expire_nxt = 1'b1;
            count_nxt  = mode ? reload_val : '0;
        end else if (tick && (state == COUNT) && (count != '0)) begin
            count_nxt = count - WIDTH'(1);
        end
    end

    // Count, reload value, mode and registered expiry pulse
    always_ff @(posedge Clk) begin
        if (Reset) begin
            count      <= '0;
            reload_val <= '0;
            mode       <= 1'b0;
            expire     <= 1'b0;
        end else begin
            count  <= count_nxt;
            expire <= expire_nxt;
            if (load) begin
                reload_val <= load_data;
                mode       <= auto_reload;
            end
        end
    end

endmodule

// File: rtl/down_timer.sv
// down_timer: dual-channel down timer, channel 0 ticks every enabled cycle, channel 1 every PRESCALE enabled cycles.
// Latency: Load visible after its edge, first decrement possible one edge later; Expire is registered.
// Backpressure: none; Load outranks En for the selected channel. Macro DOWN_TIMER_STICKY_EN adds Sticky.
module down_timer
    import down_timer_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int PRESCALE = DEFAULT_PRESCALE   // power of 2, at least 2
) (
    input logic        Clk,
    input logic        Reset,
    down_timer_if.slave bus
);

    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [1:0]       load_ch;
    logic [1:0]       tick_ch;
    logic [1:0]       expire;
    logic [1:0]       busy;
    logic [WIDTH-1:0] count0;
    logic [WIDTH-1:0] count1;
    logic [PW-1:0]    prescaler;
    logic             slow_adv;

    // Select decode: Load goes to the selected channel and suppresses any tick that cycle
    always_comb begin
        load_ch           = '0;
        load_ch[CH_FAST]  = bus.Load && !bus.Slt;
        load_ch[CH_SLOW]  = bus.Load &&  bus.Slt;
        slow_adv          = bus.En && bus.Slt && !bus.Load && busy[CH_SLOW];
        tick_ch           = '0;
        tick_ch[CH_FAST]  = bus.En && !bus.Slt && !bus.Load;
        tick_ch[CH_SLOW]  = slow_adv && (prescaler == PRE_LAST);
    end

    // Prescaler for channel 1: cleared by its load, advances only while it counts
    always_ff @(posedge Clk) begin
        if (Reset)                 prescaler <= '0;
        else if (load_ch[CH_SLOW]) prescaler <= '0;
        else if (slow_adv)         prescaler <= (prescaler == PRE_LAST) ? '0 : prescaler + PW'(1);
    end

    down_timer_channel #(.WIDTH(WIDTH)) u_fast (
        .Clk         (Clk),
        .Reset       (Reset),
        .tick        (tick_ch[CH_FAST]),
        .load        (load_ch[CH_FAST]),
        .load_data   (bus.LoadData),
        .auto_reload (bus.AutoReload),
        .count       (count0),
        .expire      (expire[CH_FAST]),
        .busy        (busy[CH_FAST])
    );

    down_timer_channel #(.WIDTH(WIDTH)) u_slow (
        .Clk         (Clk),
        .Reset       (Reset),
        .tick        (tick_ch[CH_SLOW]),
        .load        (load_ch[CH_SLOW]),
        .load_data   (bus.LoadData),
        .auto_reload (bus.AutoReload),
        .count       (count1),
        .expire      (expire[CH_SLOW]),
        .busy        (busy[CH_SLOW])
    );

    assign bus.Output0 = count0;
    assign bus.Output1 = count1;
    assign bus.Expire  = expire;
    assign bus.Busy    = busy;

`ifdef DOWN_TIMER_STICKY_EN
    logic [1:0] sticky;

    // Sticky expiry flags: set from the Expire pulse, cleared by a load to that channel, set wins
    always_ff @(posedge Clk) begin
        if (Reset) sticky <= '0;
        else       sticky <= (sticky & ~load_ch) | expire;
    end

    assign bus.Sticky = sticky;
`else
    // No sticky flags in this build; expiry is only visible as the one-cycle pulse.
`endif

endmodule

// File: tb/tb_down_timer.sv
// tb_down_timer: scoreboard bench for down_timer; expected state pushed per driven cycle, popped after the edge.
// Latency: compares every cycle at posedge+1.
// Backpressure: n/a.
module tb_down_timer;

    localparam int W = 64;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    down_timer_if #(.WIDTH(W)) bus ();

    down_timer #(.WIDTH(W), .PRESCALE(4)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    typedef struct {
        logic [W-1:0] o0;
        logic [W-1:0] o1;
        logic [1:0]   exp;
        logic [1:0]   busy;
        logic [1:0]   stk;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference state
    logic [W-1:0] m_cnt [2];
    logic [W-1:0] m_rel [2];
    logic         m_mode[2];
    logic         m_busy[2];
    logic [1:0]   m_exp;
    logic [1:0]   m_stk;
    int           m_pre;

    task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, act, req);
        end
    endtask

    task automatic model(input logic rst, input logic en, input logic slt, input logic ld,
                         input logic [W-1:0] ldat, input logic ar);
        logic [1:0] e_nxt;
        logic [1:0] s_nxt;
        logic       fire;
        int         c;
        e_nxt = 2'b00;
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_cnt[i] = '0; m_rel[i] = '0; m_mode[i] = 1'b0; m_busy[i] = 1'b0;
            end
            m_pre = 0;
            s_nxt = 2'b00;
        end else begin
            c = slt ? 1 : 0;
            s_nxt = m_stk;
            if (ld) s_nxt[c] = 1'b0;
            s_nxt = s_nxt | m_exp;
            if (ld) begin
                m_cnt[c]  = ldat;
                m_rel[c]  = ldat;
                m_mode[c] = ar;
                m_busy[c] = (ldat != 0);
                if (c == 1) m_pre = 0;
            end else if (en && m_busy[c]) begin
                fire = 1'b1;
                if (c == 1) begin
                    fire  = (m_pre == 3);
                    m_pre = (m_pre + 1) % 4;
                end
                if (fire) begin
                    if (m_cnt[c] == 1) begin
                        e_nxt[c]  = 1'b1;
                        m_cnt[c]  = m_mode[c] ? m_rel[c] : '0;
                        m_busy[c] = m_mode[c];
                    end else begin
                        m_cnt[c] = m_cnt[c] - 1;
                    end
                end
            end
        end
        m_exp = e_nxt;
        m_stk = s_nxt;
    endtask

    task automatic step(input logic rst, input logic en, input logic slt, input logic ld,
                        input logic [W-1:0] ldat, input logic ar, input string tag);
        exp_t e;
        Reset          = rst;
        bus.En         = en;
        bus.Slt        = slt;
        bus.Load       = ld;
        bus.LoadData   = ldat;
        bus.AutoReload = ar;
        model(rst, en, slt, ld, ldat, ar);
        e.o0 = m_cnt[0]; e.o1 = m_cnt[1]; e.exp = m_exp;
        e.busy = {m_busy[1], m_busy[0]}; e.stk = m_stk;
        sb.push_back(e);
        @(posedge Clk);
        #1;
        e = sb.pop_front();
        check({tag, ".out0"}, bus.Output0, e.o0);
        check({tag, ".out1"}, bus.Output1, e.o1);
        check({tag, ".expire"}, W'(bus.Expire), W'(e.exp));
        check({tag, ".busy"}, W'(bus.Busy), W'(e.busy));
`ifdef DOWN_TIMER_STICKY_EN
        check({tag, ".sticky"}, W'(bus.Sticky), W'(e.stk));
`endif
    endtask

    task automatic load(input logic ch, input logic [W-1:0] v, input logic ar, input string tag);
        step(1'b0, 1'b0, ch, 1'b1, v, ar, tag);
    endtask

    task automatic run(input logic en, input logic ch, input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, en, ch, 1'b0, '0, 1'b0, tag);
    endtask

    logic [W-1:0] hold1;

    initial begin
        m_exp = 2'b00;
        m_stk = 2'b00;

        // Reset state
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, "rst");
        step(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, "rst");
        check("rst.out0_zero", bus.Output0, 0);
        check("rst.busy_zero", W'(bus.Busy), 0);

        // Reset mid-count
        load(1'b0, 5, 1'b0, "midrst.load");
        run(1'b1, 1'b0, 2, "midrst.tick");
        check("midrst.before", bus.Output0, 3);
        step(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, "midrst.rst");
        check("midrst.out0", bus.Output0, 0);
        check("midrst.busy", W'(bus.Busy), 0);
        check("midrst.expire", W'(bus.Expire), 0);
        run(1'b1, 1'b0, 3, "midrst.en");
        check("midrst.hold", bus.Output0, 0);

        // One-shot on channel 0
        load(1'b0, 3, 1'b0, "oneshot.load");
        run(1'b1, 1'b0, 1, "oneshot.t1");
        check("oneshot.c1", bus.Output0, 2);
        check("oneshot.e1", W'(bus.Expire), 0);
        run(1'b1, 1'b0, 1, "oneshot.t2");
        check("oneshot.c2", bus.Output0, 1);
        run(1'b1, 1'b0, 1, "oneshot.t3");
        check("oneshot.c3", bus.Output0, 0);
        check("oneshot.e3", W'(bus.Expire), 1);
        check("oneshot.busy3", W'(bus.Busy), 0);
        run(1'b1, 1'b0, 2, "oneshot.after");
        check("oneshot.e_after", W'(bus.Expire), 0);

        // Periodic on channel 1
        load(1'b1, 2, 1'b1, "periodic.load");
        run(1'b1, 1'b1, 4, "periodic.a");
        check("periodic.c4", bus.Output1, 1);
        run(1'b1, 1'b1, 4, "periodic.b");
        check("periodic.c8", bus.Output1, 2);
        check("periodic.e8", W'(bus.Expire), 2);
        run(1'b1, 1'b1, 8, "periodic.c");
        check("periodic.e16", W'(bus.Expire), 2);
        check("periodic.busy16", W'(bus.Busy), 2);

        // Load vs En collision, with channel 1 prescaler mid-way
        load(1'b0, 4, 1'b0, "coll.load4");
        run(1'b1, 1'b1, 2, "coll.pre");
        hold1 = bus.Output1;
        step(1'b0, 1'b1, 1'b0, 1'b1, 9, 1'b0, "coll.hit");
        check("coll.out0", bus.Output0, 9);
        check("coll.out1", bus.Output1, hold1);
        run(1'b1, 1'b1, 2, "coll.post");
        check("coll.pre_kept", bus.Output1, 1);

        // Zero load and hold
        load(1'b1, 0, 1'b0, "zero.load");
        check("zero.busy1", W'(bus.Busy[1]), 0);
        for (int i = 0; i < 10; i++) begin
            run(1'b1, 1'b1, 1, "zero.en");
            check("zero.noexp", W'(bus.Expire), 0);
        end
        check("zero.out1", bus.Output1, 0);
        load(1'b1, 7, 1'b0, "hold.load");
        for (int i = 0; i < 10; i++) run(1'b0, 1'($urandom_range(0, 1)), 1, "hold.en0");
        check("hold.out1", bus.Output1, 7);

        // Sticky behaviour (flags only compared in the sticky build)
        load(1'b0, 1, 1'b0, "sticky.load");
        run(1'b1, 1'b0, 1, "sticky.expire");
        run(1'b0, 1'b0, 1, "sticky.set");
        load(1'b1, 3, 1'b0, "sticky.other");
        load(1'b0, 2, 1'b0, "sticky.clear");
        load(1'b0, 1, 1'b0, "sticky.load2");
        run(1'b1, 1'b0, 1, "sticky.expire2");
        load(1'b0, 5, 1'b0, "sticky.setwins");
`ifdef DOWN_TIMER_STICKY_EN
        check("sticky.setwins_bit", W'(bus.Sticky[0]), 1);
`endif

        // Random traffic against the scoreboard
        for (int i = 0; i < 400; i++) begin
            logic [W-1:0] v;
            v = ($urandom_range(0, 15) == 0) ? {$urandom, $urandom} : W'($urandom_range(0, 5));
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
                 v, 1'($urandom_range(0, 1)), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
